// File: rtl/stopwatch_core_pkg.sv
// Shared types and constants for the stopwatch time-keeping stage.
// Holds the FSM encoding, BCD digit limits and the time bundle.
package stopwatch_core_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [BCD_W-1:0] TENTHS_MAX   = 4'd9;
  localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] MIN_MAX      = 4'd9;

  typedef struct packed {
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] tenths;
  } bcd_time_t;

  // True when the time is at its largest value, 9:59.9
  function automatic logic at_limit(bcd_time_t t);
    return (t.min == MIN_MAX) && (t.sec_tens == SEC_TENS_MAX) &&
           (t.sec_ones == SEC_ONES_MAX) && (t.tenths == TENTHS_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit counting 0..MAX with synchronous clear.
// Carry is combinational so a chain ripples within one cycle.
module bcd_digit_counter
  import stopwatch_core_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = en && (q == MAX);

  // Digit register: clear wins, otherwise advance and roll past MAX
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time-keeping stage: counts 100 ms ticks as BCD M:SS.t
// under start/stop, clear and lap control, feeding the display.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic             running,
  output logic             frozen,
  output logic             overflow,
  output logic [BCD_W-1:0] d_tenths,
  output logic [BCD_W-1:0] d_sec_ones,
  output logic [BCD_W-1:0] d_sec_tens,
  output logic [BCD_W-1:0] d_min
);

  state_t    state, state_nx;
  bcd_time_t count, snap, shown;
  logic      in_run, at_max, roll, cnt_en, clr_count;
  logic      c_tenths, c_sec_ones, c_sec_tens, c_min;

  assign in_run    = (state == RUN);
  assign at_max    = at_limit(count);
  assign roll      = in_run && tick && at_max;
  assign cnt_en    = in_run && tick && (WRAP || !at_max);
  assign clr_count = clear && !in_run;

  bcd_digit_counter #(.MAX(TENTHS_MAX)) u_tenths (
    .clock(clock), .reset(reset), .clr(clr_count),
    .en(cnt_en), .q(count.tenths), .carry(c_tenths)
  );

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clock(clock), .reset(reset), .clr(clr_count),
    .en(c_tenths), .q(count.sec_ones), .carry(c_sec_ones)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .reset(reset), .clr(clr_count),
    .en(c_sec_ones), .q(count.sec_tens), .carry(c_sec_tens)
  );

  bcd_digit_counter #(.MAX(MIN_MAX)) u_min (
    .clock(clock), .reset(reset), .clr(clr_count),
    .en(c_sec_tens), .q(count.min), .carry(c_min)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: clear beats start_stop outside RUN; saturation pauses
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_stop && !clear) state_nx = RUN;
      end
      RUN: begin
        if (start_stop)     state_nx = PAUSE;
        else if (roll && !WRAP) state_nx = PAUSE;
      end
      PAUSE: begin
        if (clear)           state_nx = IDLE;
        else if (start_stop) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lap freeze, snapshot capture (pre-tick value) and overflow pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      frozen   <= 1'b0;
      snap     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= roll;
      if (clr_count) begin
        frozen <= 1'b0;
      end else if (lap) begin
        if (frozen) begin
          frozen <= 1'b0;
        end else if (in_run) begin
          frozen <= 1'b1;
          snap   <= count;
        end
      end
    end
  end

  assign running    = in_run;
  assign shown      = frozen ? snap : count;
  assign d_tenths   = shown.tenths;
  assign d_sec_ones = shown.sec_ones;
  assign d_sec_tens = shown.sec_tens;
  assign d_min      = shown.min;

  logic unused;
  assign unused = c_min;

endmodule
